// File: rtl/median_window_3x3.sv
// ---------------------------------------------------------------------------
// median_window_3x3
//
// Builds a sliding 3x3 pixel window from a raster-order pixel stream. The
// window is the front end for a 3x3 median (or any 3x3 kernel) stage.
//
// Two line buffers hold the previous two rows. A 3x3 shift register takes
// one new right-hand column per accepted pixel. A window is flagged valid
// only when all nine pixels come from the current frame and the current row
// span, so the first two rows and the first two columns of each row
// produce no output.
//
// Parameters
//   WIDTH  pixel bit width
//   IMG_W  pixels per row  (>= 3)
//   IMG_H  rows per frame  (>= 3)
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_valid        qualifies i_pixel; a pixel is accepted when i_valid=1
//   i_pixel        raster-order pixel, row-major, frame-contiguous
//   o_win_0..8     3x3 window, row-major (0 top-left, 4 centre, 8 bottom-right)
//   o_valid        window outputs are valid this cycle
//   o_frame_done   one-cycle pulse with the last window of a frame
// ---------------------------------------------------------------------------
module median_window_3x3 #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_pixel,
    output logic [WIDTH-1:0] o_win_0,
    output logic [WIDTH-1:0] o_win_1,
    output logic [WIDTH-1:0] o_win_2,
    output logic [WIDTH-1:0] o_win_3,
    output logic [WIDTH-1:0] o_win_4,
    output logic [WIDTH-1:0] o_win_5,
    output logic [WIDTH-1:0] o_win_6,
    output logic [WIDTH-1:0] o_win_7,
    output logic [WIDTH-1:0] o_win_8,
    output logic             o_valid,
    output logic             o_frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [WIDTH-1:0] r_line1 [IMG_W];   // row-1
    logic [WIDTH-1:0] r_line2 [IMG_W];   // row-2
    logic [WIDTH-1:0] r_win   [9];
    logic             r_valid;
    logic             r_frame_done;

    logic             w_accept;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_win_ok;
    logic [WIDTH-1:0] w_top_new;
    logic [WIDTH-1:0] w_mid_new;

    // Reset wins over i_valid so the first pixel after reset is (0,0).
    assign w_accept   = i_valid & ~i_rst;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);

    // Only rows >= 2 have two in-frame rows above them in the line buffers,
    // and only cols >= 2 have two in-row columns to the left in the shift
    // register; anything else would mix in wrapped or previous-frame data.
    assign w_win_ok   = (r_row >= ROW_TWO) && (r_col >= COL_TWO);

    assign w_top_new  = r_line2[r_col];
    assign w_mid_new  = r_line1[r_col];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line buffers are not cleared: stale contents are never exposed because
    // rows 0 and 1 of every frame rewrite every entry before a window is valid.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_line2[r_col] <= w_mid_new;
            r_line1[r_col] <= i_pixel;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
        end else if (w_accept) begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= w_top_new;
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= w_mid_new;
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= i_pixel;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid      <= w_accept & w_win_ok;
            r_frame_done <= w_accept & w_col_last & w_row_last;
        end
    end

    assign o_win_0      = r_win[0];
    assign o_win_1      = r_win[1];
    assign o_win_2      = r_win[2];
    assign o_win_3      = r_win[3];
    assign o_win_4      = r_win[4];
    assign o_win_5      = r_win[5];
    assign o_win_6      = r_win[6];
    assign o_win_7      = r_win[7];
    assign o_win_8      = r_win[8];
    assign o_valid      = r_valid;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_median_window_3x3.sv
// ---------------------------------------------------------------------------
// tb_median_window_3x3
//
// Directed bench for median_window_3x3 with a 4x4 image of 8-bit pixels.
// A table of per-cycle vectors covers the continuous ramp, a stall with
// window hold, back-to-back frames, and a mid-frame reset. A hand-written
// loop then feeds a ramp with randomly gapped i_valid.
// ---------------------------------------------------------------------------
module tb_median_window_3x3;

    localparam int WIDTH = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;

    logic             clk;
    logic             rst;
    logic             vld;
    logic [WIDTH-1:0] pix;
    logic [WIDTH-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
    logic             o_valid;
    logic             o_done;
    logic [71:0]      w_win;

    median_window_3x3 #(
        .WIDTH (WIDTH),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (vld),
        .i_pixel      (pix),
        .o_win_0      (win0),
        .o_win_1      (win1),
        .o_win_2      (win2),
        .o_win_3      (win3),
        .o_win_4      (win4),
        .o_win_5      (win5),
        .o_win_6      (win6),
        .o_win_7      (win7),
        .o_win_8      (win8),
        .o_valid      (o_valid),
        .o_frame_done (o_done)
    );

    assign w_win = {win0, win1, win2, win3, win4, win5, win6, win7, win8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [7:0]  pix;
        logic        ev;
        logic        ed;
        logic        cw;
        logic [71:0] ew;
    } vec_t;

    vec_t        vt[$];
    logic [71:0] ref_win [4];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [71:0] add_off(input logic [71:0] w, input int off);
        logic [71:0] r;
        for (int k = 0; k < 9; k++) begin
            r[k*8 +: 8] = w[k*8 +: 8] + 8'(off);
        end
        return r;
    endfunction

    function automatic void push(input logic r, input logic v, input logic [7:0] p,
                                 input logic ev, input logic ed, input logic cw,
                                 input logic [71:0] ew);
        vec_t x;
        x.rst = r; x.vld = v; x.pix = p;
        x.ev = ev; x.ed = ed; x.cw = cw; x.ew = ew;
        vt.push_back(x);
    endfunction

    // Pixels 10, 11, 14, 15 of a 4x4 frame complete windows 0..3.
    function automatic void add_ramp(input int base, input bit stall_after_10);
        for (int i = 0; i < 16; i++) begin
            case (i)
                10: push(1'b0, 1'b1, 8'(base + i), 1'b1, 1'b0, 1'b1, add_off(ref_win[0], base));
                11: push(1'b0, 1'b1, 8'(base + i), 1'b1, 1'b0, 1'b1, add_off(ref_win[1], base));
                14: push(1'b0, 1'b1, 8'(base + i), 1'b1, 1'b0, 1'b1, add_off(ref_win[2], base));
                15: push(1'b0, 1'b1, 8'(base + i), 1'b1, 1'b1, 1'b1, add_off(ref_win[3], base));
                default: push(1'b0, 1'b1, 8'(base + i), 1'b0, 1'b0, 1'b0, '0);
            endcase
            if (stall_after_10 && i == 10) begin
                push(1'b0, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b1, add_off(ref_win[0], base));
            end
        end
    endfunction

    initial begin
        int          idx;
        int          nwin;
        int          cyc;
        int          ndone;
        logic        v;
        logic [71:0] last_win;

        rst = 1'b1;
        vld = 1'b0;
        pix = '0;

        ref_win[0] = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8,  8'd9,  8'd10};
        ref_win[1] = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9,  8'd10, 8'd11};
        ref_win[2] = {8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14};
        ref_win[3] = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};

        // Reset, ramp with a stall after pixel 10, second frame 100..115
        // back-to-back, partial frame, reset with i_valid high, clean ramp.
        push(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, '0);
        add_ramp(0, 1'b1);
        add_ramp(100, 1'b0);
        for (int i = 0; i < 6; i++) begin
            push(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0, '0);
        end
        push(1'b1, 1'b1, 8'd99, 1'b0, 1'b0, 1'b1, '0);
        add_ramp(0, 1'b0);

        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].rst;
            vld = vt[i].vld;
            pix = vt[i].pix;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid", i), 72'(o_valid), 72'(vt[i].ev));
            chk($sformatf("v%0d frame_done", i), 72'(o_done), 72'(vt[i].ed));
            if (vt[i].cw) begin
                chk($sformatf("v%0d window", i), w_win, vt[i].ew);
            end
        end

        // Randomly gapped ramp; the previous ramp ended on pixel 15 so this
        // starts a fresh frame.
        idx      = 0;
        nwin     = 0;
        cyc      = 0;
        ndone    = 0;
        last_win = w_win;
        while (idx < 16 && cyc < 200) begin
            v   = (cyc < 2) ? 1'(cyc) : 1'($urandom_range(0, 1));
            rst = 1'b0;
            vld = v;
            pix = v ? 8'(idx) : 8'hA5;
            @(posedge clk);
            #1;
            if (!v) begin
                chk($sformatf("gap c%0d valid", cyc), 72'(o_valid), 72'(0));
                chk($sformatf("gap c%0d hold", cyc), w_win, last_win);
            end
            if (o_done) ndone++;
            if (o_valid) begin
                if (nwin < 4) begin
                    chk($sformatf("gap win%0d", nwin), w_win, ref_win[nwin]);
                end
                nwin++;
            end
            last_win = w_win;
            if (v) idx++;
            cyc++;
        end
        chk("gap pixels fed", 72'(idx), 72'(16));
        chk("gap window count", 72'(nwin), 72'(4));
        chk("gap done pulses", 72'(ndone), 72'(1));
        chk("gap last done", 72'(o_done), 72'(1));

        vld = 1'b0;
        @(posedge clk);
        #1;
        chk("idle valid", 72'(o_valid), 72'(0));
        chk("idle done", 72'(o_done), 72'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
